ritc_vcdl_seq: RTL and testbench
================================

RITC_VCDL_SEQ -- requirements
Module: ritc_vcdl_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of RITC VCDL outputs driven.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the burst-length/period and pulse counters.
REQ-003 SHALL have port sysclk_i  in  1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i  in  1: synchronous, active-low reset.
REQ-005 SHALL have port sync_i  in  1: SYNC strobe, one cycle high per VCDL period.
REQ-006 SHALL have port mode_i  in  2: 00 OFF, 01 CONT, 10 BURST, 11 PERIODIC.
REQ-007 SHALL have port count_i  in  CNT_WIDTH: burst length (BURST) or period in syncs (PERIODIC).
REQ-008 SHALL have port ch_mask_i  in  NUM_CH: per-channel enable.
REQ-009 SHALL have port start_i  in  1: one-cycle arm request.
REQ-010 SHALL have port stop_i  in  1: one-cycle abort/stop request.
REQ-011 SHALL have port vcdl_o  out  NUM_CH: registered VCDL pulses.
REQ-012 SHALL have port busy_o  out  1: high while in RUN.
REQ-013 SHALL have port done_o  out  1: one-cycle pulse on leaving RUN.
REQ-014 SHALL have port pulse_count_o  out  CNT_WIDTH: fires since last accepted start.

Function
REQ-015 SHALL implement a three-state machine: IDLE, RUN, DONE.
- IDLE->RUN on start_i with mode_i != OFF and stop_i low.
- RUN->DONE per REQ-019/020.
- DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL latch mode_i, count_i and ch_mask_i on an accepted start; changes to these inputs outside that cycle SHALL have no effect.
REQ-017 SHALL clear pulse_count_o and the period counter on an accepted start, and ignore start_i outside IDLE.
REQ-018 SHALL "fire" only on a RUN cycle with sync_i high and stop_i low; a fire SHALL drive vcdl_o = latched mask for exactly the next cycle (latency 1), otherwise vcdl_o = 0.
REQ-019 SHALL, in CONT mode, fire on every sync_i until stop_i.
REQ-020 SHALL, in BURST mode, fire on every sync_i and go to DONE on the cycle after the fire that makes pulse_count equal the latched count.
- A latched count of 0 SHALL go to DONE after one RUN cycle with no fire.
REQ-021 SHALL, in PERIODIC mode:
- fire on the first sync_i after start, then on every P-th sync_i thereafter, where P = latched count and P=0 is treated as 1;
- wrap the period counter from P-1 to 0;
- run until stop_i.
REQ-022 SHALL, on stop_i in RUN, go to DONE next cycle; stop_i coincident with sync_i SHALL suppress that fire.
REQ-023 SHALL ignore stop_i in IDLE and DONE; start_i and stop_i together in IDLE SHALL leave the block in IDLE.
REQ-024 SHALL increment pulse_count_o by 1 per fire, saturating at all-ones (no wrap).
REQ-025 SHALL count fires with a zero latched mask normally, with vcdl_o staying 0.
REQ-026 SHALL assert busy_o exactly while in RUN, and done_o exactly while in DONE.

Reset
REQ-027 SHALL, with rst_n_i low at a clock edge:
- set state to IDLE;
- set vcdl_o, busy_o, done_o, pulse_count_o and all latched registers/counters to 0.
REQ-028 SHALL, on reset during RUN, produce no done_o pulse and drive vcdl_o to 0 from the next cycle, even if a fire occurred in the reset cycle.

Structure
REQ-029 SHALL take mode encodings (OFF/CONT/BURST/PERIODIC) and state encodings (IDLE/RUN/DONE) from a shared package, ritc_vcdl_pkg.
REQ-030 SHALL place the PERIODIC sync divider (period counter with P=0->1 rule and wrap) in one sub-module, ritc_vcdl_period_cnt; all other logic SHALL be in ritc_vcdl_seq.

Verification
REQ-031 SHALL cover BURST: NUM_CH=2, count=3, mask=11, syncs every 8 cycles -> three vcdl_o=11 pulses, each 1 cycle after a sync; done_o once; pulse_count_o=3; busy_o low after.
REQ-032 SHALL cover PERIODIC: count=4, mask=01, 12 syncs -> fires on syncs 1, 5, 9 only, vcdl_o=01; stop_i then gives done_o and pulse_count_o=3.
REQ-033 SHALL cover stop/sync coincidence: CONT with stop_i on the 3rd sync -> exactly 2 pulses and done_o one cycle later.
REQ-034 SHALL cover corner starts:
- BURST count=0 -> no vcdl_o pulse, done_o after one busy cycle;
- start_i with mode OFF -> stays IDLE;
- start_i+stop_i together -> stays IDLE.
REQ-035 SHALL cover saturation: CNT_WIDTH=2, CONT for 6 syncs -> pulse_count_o holds 3.
REQ-036 SHALL cover reset mid-BURST (count=5, after 2 fires) -> all outputs 0 next cycle, no done_o, vcdl_o stays 0 on later syncs.

Source files
------------

// File: rtl/ritc_vcdl_pkg.sv
// -----------------------------------------------------------------------------
// ritc_vcdl_pkg
// Shared encodings for the RITC VCDL pulse sequencer.
//   mode_e  : OFF / CONT / BURST / PERIODIC, matching the 2-bit mode_i field
//   state_e : sequencer states IDLE / RUN / DONE
// -----------------------------------------------------------------------------
package ritc_vcdl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_CONT     = 2'b01,
    MODE_BURST    = 2'b10,
    MODE_PERIODIC = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : ritc_vcdl_pkg

// File: rtl/ritc_vcdl_period_cnt.sv
// -----------------------------------------------------------------------------
// ritc_vcdl_period_cnt
// Sync divider for PERIODIC mode. Counts accepted syncs modulo P, where
// P = period_i and a period of 0 behaves as 1. hit_o is high while the
// counter sits at 0, i.e. on the first sync after a clear and every P-th
// sync after that.
// Ports:
//   clk_i     : clock, rising edge
//   rst_n_i   : synchronous active-low reset
//   clear_i   : force counter to 0 (accepted start)
//   adv_i     : advance by one sync
//   period_i  : latched period P
//   hit_o     : counter is at 0 (this sync is a firing sync)
// -----------------------------------------------------------------------------
module ritc_vcdl_period_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clear_i,
  input  logic                 adv_i,
  input  logic [CNT_WIDTH-1:0] period_i,
  output logic                 hit_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] last_val;

  // P=0 is treated as P=1, so the terminal value is 0 in both cases.
  assign last_val = (period_i == '0) ? '0 : period_i - 1'b1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      // >= rather than == keeps the counter bounded if it ever sits past the terminal value.
      cnt_d = (cnt_q >= last_val) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is synchronous here; rst_n_i is just another input sampled at the clock edge.
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == '0);

endmodule : ritc_vcdl_period_cnt

// File: rtl/ritc_vcdl_seq.sv
// -----------------------------------------------------------------------------
// ritc_vcdl_seq
// Sequencer that gates the SYNC strobe onto the RITC VCDL outputs.
// An accepted start latches mode/count/mask and enters RUN; each "fire" (RUN,
// sync_i high, stop_i low, mode allows) drives vcdl_o = latched mask for the
// following cycle. RUN ends via stop_i or BURST completion, passing through a
// one-cycle DONE state.
// Ports:
//   sysclk_i      : clock, rising edge
//   rst_n_i       : synchronous active-low reset
//   sync_i        : SYNC strobe
//   mode_i        : 00 OFF, 01 CONT, 10 BURST, 11 PERIODIC
//   count_i       : burst length (BURST) or period in syncs (PERIODIC)
//   ch_mask_i     : per-channel enable
//   start_i       : arm request (honoured in IDLE only)
//   stop_i        : abort/stop request (honoured in RUN only)
//   vcdl_o        : registered VCDL pulses
//   busy_o        : high while in RUN
//   done_o        : high while in DONE
//   pulse_count_o : fires since last accepted start, saturating
// -----------------------------------------------------------------------------
module ritc_vcdl_seq
  import ritc_vcdl_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 sysclk_i,
  input  logic                 rst_n_i,
  input  logic                 sync_i,
  input  logic [1:0]           mode_i,
  input  logic [CNT_WIDTH-1:0] count_i,
  input  logic [NUM_CH-1:0]    ch_mask_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic [NUM_CH-1:0]    vcdl_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] pulse_count_o
);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [NUM_CH-1:0]    mask_q, mask_d;
  logic [CNT_WIDTH-1:0] pc_q, pc_d;
  logic [NUM_CH-1:0]    vcdl_q, vcdl_d;

  logic                 accept;
  logic                 run;
  logic                 fire_en;
  logic                 fire;
  logic                 burst_end;
  logic                 period_hit;
  logic [CNT_WIDTH:0]   pc_inc;

  assign run    = (state_q == ST_RUN);
  assign accept = (state_q == ST_IDLE) && start_i && !stop_i &&
                  (mode_e'(mode_i) != MODE_OFF);

  // One extra bit so the BURST completion compare cannot alias on wrap.
  assign pc_inc = {1'b0, pc_q} + 1'b1;

  ritc_vcdl_period_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_period_cnt (
    .clk_i    (sysclk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (accept),
    .adv_i    (run && sync_i && !stop_i),
    .period_i (count_q),
    .hit_o    (period_hit)
  );

  // Fire qualification and BURST termination.
  always_comb begin
    fire_en   = 1'b0;
    burst_end = 1'b0;
    unique case (mode_q)
      MODE_CONT:     fire_en = 1'b1;
      MODE_BURST:    fire_en = (count_q != '0);
      MODE_PERIODIC: fire_en = period_hit;
      default:       fire_en = 1'b0;
    endcase
    fire = run && sync_i && !stop_i && fire_en;
    if (mode_q == MODE_BURST) begin
      // A zero-length burst leaves after one RUN cycle; otherwise leave right
      // after the fire that brings the count up to the latched length.
      burst_end = (count_q == '0) || (fire && (pc_inc == {1'b0, count_q}));
    end
  end

  // Next state, latched configuration, counter and output pulse.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    mask_d  = mask_q;
    pc_d    = pc_q;
    vcdl_d  = fire ? mask_q : '0;

    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (stop_i || burst_end) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      mode_d  = mode_e'(mode_i);
      count_d = count_i;
      mask_d  = ch_mask_i;
      pc_d    = '0;
    end else if (fire && (pc_q != '1)) begin
      pc_d = pc_inc[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_OFF;
      count_q <= '0;
      mask_q  <= '0;
      pc_q    <= '0;
      vcdl_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      pc_q    <= pc_d;
      vcdl_q  <= vcdl_d;
    end
  end

  assign vcdl_o        = vcdl_q;
  assign busy_o        = (state_q == ST_RUN);
  assign done_o        = (state_q == ST_DONE);
  assign pulse_count_o = pc_q;

endmodule : ritc_vcdl_seq

// File: tb/tb_ritc_vcdl_seq.sv
module tb_ritc_vcdl_seq;
  import ritc_vcdl_pkg::*;

  localparam int NUM_CH = 2;
  localparam int CW     = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [CW-1:0] count = '0;
  logic [1:0]    mask = 2'b00;
  logic          start = 1'b0;
  logic          stop = 1'b0;

  logic [1:0]    vcdl;
  logic          busy, done;
  logic [CW-1:0] pc;

  logic [1:0]    vcdl2;
  logic          busy2, done2;
  logic [1:0]    pc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ritc_vcdl_seq #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW)) dut (
    .sysclk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .mode_i(mode),
    .count_i(count), .ch_mask_i(mask), .start_i(start), .stop_i(stop),
    .vcdl_o(vcdl), .busy_o(busy), .done_o(done), .pulse_count_o(pc)
  );

  // Narrow-counter instance for the saturation case; shares all stimulus.
  ritc_vcdl_seq #(.NUM_CH(NUM_CH), .CNT_WIDTH(2)) dut2 (
    .sysclk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .mode_i(mode),
    .count_i(count[1:0]), .ch_mask_i(mask), .start_i(start), .stop_i(stop),
    .vcdl_o(vcdl2), .busy_o(busy2), .done_o(done2), .pulse_count_o(pc2)
  );

  typedef struct {
    logic          rst_n, start, stop, sync;
    logic [1:0]    mode;
    logic [CW-1:0] count;
    logic [1:0]    mask;
    logic [1:0]    e_vcdl;
    logic          e_busy, e_done;
    logic [CW-1:0] e_pc;
  } vec_t;

  vec_t tbl [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [CW-1:0] c, input logic [1:0] msk);
    mode = m; count = c; mask = msk; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_pc", {24'd0, pc}, 32'd0);
  endtask

  // n syncs spaced gap cycles apart. Bit i-1 of exp_fire says whether sync i
  // fires (vcdl_o = val on the following cycle). done_o is expected only right
  // after sync stop_at or sync done_at (0 = never).
  task automatic run_syncs(input int n, input int gap, input int stop_at, input int done_at,
                           input logic [15:0] exp_fire, input logic [1:0] val);
    for (int i = 1; i <= n; i++) begin
      for (int g = 1; g < gap; g++) begin
        tick();
        check("gap_vcdl", {30'd0, vcdl}, 32'd0);
        check("gap_done", {31'd0, done}, 32'd0);
      end
      sync = 1'b1;
      stop = (i == stop_at);
      tick();
      sync = 1'b0;
      stop = 1'b0;
      check($sformatf("sync%0d_vcdl", i), {30'd0, vcdl}, exp_fire[i-1] ? {30'd0, val} : 32'd0);
      check($sformatf("sync%0d_done", i), {31'd0, done},
            ((i == stop_at) || (i == done_at)) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    //         rst start stop sync mode           cnt  mask | vcdl busy done pc
    tbl[0]  = '{0, 0, 0, 0, MODE_OFF,      8'd0, 2'b00, 2'b00, 0, 0, 8'd0};
    tbl[1]  = '{1, 1, 0, 0, MODE_OFF,      8'd3, 2'b11, 2'b00, 0, 0, 8'd0};
    tbl[2]  = '{1, 0, 0, 1, MODE_CONT,     8'd3, 2'b11, 2'b00, 0, 0, 8'd0};
    tbl[3]  = '{1, 1, 1, 0, MODE_CONT,     8'd3, 2'b11, 2'b00, 0, 0, 8'd0};
    tbl[4]  = '{1, 0, 0, 0, MODE_CONT,     8'd3, 2'b11, 2'b00, 0, 0, 8'd0};
    tbl[5]  = '{1, 1, 0, 0, MODE_BURST,    8'd0, 2'b11, 2'b00, 1, 0, 8'd0};
    tbl[6]  = '{1, 0, 0, 1, MODE_BURST,    8'd0, 2'b11, 2'b00, 0, 1, 8'd0};
    tbl[7]  = '{1, 0, 0, 0, MODE_BURST,    8'd0, 2'b11, 2'b00, 0, 0, 8'd0};
    tbl[8]  = '{1, 1, 0, 0, MODE_CONT,     8'd0, 2'b10, 2'b00, 1, 0, 8'd0};
    tbl[9]  = '{1, 0, 0, 1, MODE_OFF,      8'd5, 2'b01, 2'b10, 1, 0, 8'd1};
    tbl[10] = '{1, 0, 0, 0, MODE_OFF,      8'd5, 2'b01, 2'b00, 1, 0, 8'd1};
    tbl[11] = '{1, 1, 0, 1, MODE_BURST,    8'd0, 2'b01, 2'b10, 1, 0, 8'd2};
    tbl[12] = '{1, 0, 1, 0, MODE_CONT,     8'd0, 2'b01, 2'b00, 0, 1, 8'd2};
    tbl[13] = '{1, 0, 1, 0, MODE_CONT,     8'd0, 2'b01, 2'b00, 0, 0, 8'd2};
    tbl[14] = '{1, 0, 1, 0, MODE_CONT,     8'd0, 2'b01, 2'b00, 0, 0, 8'd2};
    tbl[15] = '{1, 1, 0, 0, MODE_PERIODIC, 8'd0, 2'b11, 2'b00, 1, 0, 8'd0};
    tbl[16] = '{1, 0, 0, 1, MODE_PERIODIC, 8'd0, 2'b11, 2'b11, 1, 0, 8'd1};
    tbl[17] = '{1, 0, 0, 1, MODE_PERIODIC, 8'd0, 2'b11, 2'b11, 1, 0, 8'd2};
    tbl[18] = '{1, 0, 1, 1, MODE_PERIODIC, 8'd0, 2'b11, 2'b00, 0, 1, 8'd2};
    tbl[19] = '{1, 0, 0, 0, MODE_PERIODIC, 8'd0, 2'b11, 2'b00, 0, 0, 8'd2};
    tbl[20] = '{1, 1, 0, 0, MODE_BURST,    8'd2, 2'b00, 2'b00, 1, 0, 8'd0};
    tbl[21] = '{1, 0, 0, 1, MODE_BURST,    8'd2, 2'b00, 2'b00, 1, 0, 8'd1};
    tbl[22] = '{1, 0, 0, 1, MODE_BURST,    8'd2, 2'b00, 2'b00, 0, 1, 8'd2};
    tbl[23] = '{1, 0, 0, 0, MODE_BURST,    8'd2, 2'b00, 2'b00, 0, 0, 8'd2};

    for (int i = 0; i < 24; i++) begin
      rst_n = tbl[i].rst_n; start = tbl[i].start; stop = tbl[i].stop;
      sync  = tbl[i].sync;  mode  = tbl[i].mode;  count = tbl[i].count;
      mask  = tbl[i].mask;
      tick();
      check($sformatf("v%0d_vcdl", i), {30'd0, vcdl}, {30'd0, tbl[i].e_vcdl});
      check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      check($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, tbl[i].e_done});
      check($sformatf("v%0d_pc", i), {24'd0, pc}, {24'd0, tbl[i].e_pc});
    end
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; sync = 1'b0;
    tick();

    // BURST length 3, syncs every 8 cycles; the 4th sync must not fire.
    do_start(MODE_BURST, 8'd3, 2'b11);
    run_syncs(4, 8, 0, 3, 16'b0111, 2'b11);
    check("burst_pc", {24'd0, pc}, 32'd3);
    check("burst_busy_after", {31'd0, busy}, 32'd0);

    // PERIODIC P=4: fires on syncs 1, 5, 9.
    do_start(MODE_PERIODIC, 8'd4, 2'b01);
    run_syncs(12, 3, 0, 0, 16'h0111, 2'b01);
    check("per_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("per_stop_done", {31'd0, done}, 32'd1);
    check("per_pc", {24'd0, pc}, 32'd3);
    tick();
    check("per_idle_done", {31'd0, done}, 32'd0);
    check("per_idle_busy", {31'd0, busy}, 32'd0);

    // CONT with stop on the 3rd sync: two pulses, done right after.
    do_start(MODE_CONT, 8'd0, 2'b11);
    run_syncs(4, 4, 3, 0, 16'b0011, 2'b11);
    check("stop_pc", {24'd0, pc}, 32'd2);

    // Saturation on the 2-bit instance; the 8-bit one keeps counting.
    do_start(MODE_CONT, 8'd0, 2'b11);
    run_syncs(6, 2, 0, 0, 16'h003f, 2'b11);
    check("sat_pc2", {30'd0, pc2}, 32'd3);
    check("sat_pc", {24'd0, pc}, 32'd6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

    // Reset mid-BURST, with a would-be fire in the reset cycle.
    do_start(MODE_BURST, 8'd5, 2'b11);
    run_syncs(2, 4, 0, 0, 16'b0011, 2'b11);
    check("rst_pre_pc", {24'd0, pc}, 32'd2);
    sync = 1'b1; rst_n = 1'b0;
    tick();
    sync = 1'b0; rst_n = 1'b1;
    check("rst_vcdl", {30'd0, vcdl}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pc", {24'd0, pc}, 32'd0);
    run_syncs(3, 4, 0, 0, 16'b0000, 2'b11);
    check("rst_after_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ritc_vcdl_seq
